// File: rtl/dmem_responder.sv
// Multi-cycle responder between the data cache and a byte-addressed backing memory.
// Optional DMEM_ADDR_CHECK_EN adds resp_err_o for out-of-range or misaligned word accesses.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic                  req_byte_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  stall_o
`ifdef DMEM_ADDR_CHECK_EN
    ,
    output logic                  resp_err_o
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    logic [7:0] mem [2**ADDR_WIDTH];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  byte_q, byte_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  req_err;
    logic                  done;
    logic [DATA_WIDTH-1:0] load_data;

`ifdef DMEM_ADDR_CHECK_EN
    assign req_err = (|req_addr_i[31:ADDR_WIDTH]) | (~req_byte_i & (|req_addr_i[1:0]));
    assign resp_err_o = resp_err_q;
`else
    // Upper address bits are dropped silently, so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^{req_addr_i[31:ADDR_WIDTH], resp_err_q};
    assign req_err = 1'b0;
`endif

    assign done = (state_q == StWait) && (cnt_q == 4'd0);

    // Word accesses force alignment by replacing the low two address bits.
    assign load_data = byte_q ? {24'b0, mem[addr_q]}
                              : {mem[{addr_q[ADDR_WIDTH-1:2], 2'b11}],
                                 mem[{addr_q[ADDR_WIDTH-1:2], 2'b10}],
                                 mem[{addr_q[ADDR_WIDTH-1:2], 2'b01}],
                                 mem[{addr_q[ADDR_WIDTH-1:2], 2'b00}]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        byte_d       = byte_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    byte_d  = req_byte_i;
                    err_d   = req_err;
                    addr_d  = req_addr_i[ADDR_WIDTH-1:0];
                    wdata_d = req_wdata_i;
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    rdata_d      = (we_q || err_q) ? '0 : load_data;
                    resp_err_d   = err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            byte_q       <= byte_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // A reset landing on the commit edge discards the pending store.
    always_ff @(posedge clk_i) begin
        if (!rst_i && done && we_q && !err_q) begin
            if (byte_q) begin
                mem[addr_q] <= wdata_q[7:0];
            end else begin
                mem[{addr_q[ADDR_WIDTH-1:2], 2'b00}] <= wdata_q[7:0];
                mem[{addr_q[ADDR_WIDTH-1:2], 2'b01}] <= wdata_q[15:8];
                mem[{addr_q[ADDR_WIDTH-1:2], 2'b10}] <= wdata_q[23:16];
                mem[{addr_q[ADDR_WIDTH-1:2], 2'b11}] <= wdata_q[31:24];
            end
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign stall_o      = (state_q == StWait)
                        | ((state_q == StIdle) & req_valid_i)
                        | ((state_q == StResp) & req_valid_i & ~resp_valid_q);

endmodule
